// File: rtl/vga_scan_driver_if.sv
// Avalon-MM slave write bus feeding the VGA scan driver register file.
interface vga_scan_driver_if;
  logic        chipselect;
  logic        write;
  logic [2:0]  address;
  logic [31:0] writedata;

  modport master (
    output chipselect,
    output write,
    output address,
    output writedata
  );

  modport slave (
    input chipselect,
    input write,
    input address,
    input writedata
  );
endinterface

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: VGA raster timing generator running at clk/2, with an
// 8-entry double-buffered register file.
// - Avalon writes land in the pending bank.
// - The pending bank is copied into the active bank once per frame, at the
//   last visible pixel.
// - The active bank is presented round-robin to the pixel pipeline.
module vga_scan_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int HS_START = 656,
  parameter int HS_END   = 752,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int VS_START = 490,
  parameter int VS_END   = 492
) (
  input  logic                clk,
  input  logic                reset,
  vga_scan_driver_if.slave    avs,
  output logic [9:0]          hcount,
  output logic [9:0]          vcount,
  output logic [2:0]          reg_addr,
  output logic [31:0]         reg_data,
  input  logic [23:0]         RGB_input,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_n,
  output logic                VGA_CLK,
  output logic                frame_start
);

  localparam int NUM_REGS = 8;

  localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_COMMIT_C = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_COMMIT_C = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START_C = 10'(HS_START);
  localparam logic [9:0] HS_END_C   = 10'(HS_END);
  localparam logic [9:0] VS_START_C = 10'(VS_START);
  localparam logic [9:0] VS_END_C   = 10'(VS_END);

  // Scan state.
  logic        pix_en_q, pix_en_d;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [2:0]  reg_addr_q, reg_addr_d;

  // Register file banks.
  logic [31:0] pending_q [NUM_REGS];
  logic [31:0] pending_d [NUM_REGS];
  logic [31:0] active_q  [NUM_REGS];
  logic [31:0] active_d  [NUM_REGS];

  // Video output stage, one pixel tick behind the scan position.
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        frame_start_q, frame_start_d;

  // Decoded position.
  logic        wr_en_s;
  logic        visible_s;
  logic        hs_on_s;
  logic        vs_on_s;
  logic        h_last_s;
  logic        v_last_s;
  logic        commit_s;

  // Decode the current scan position and the bus write strobe.
  always_comb begin
    wr_en_s   = avs.chipselect & avs.write;
    visible_s = (hcount_q < H_ACTIVE_C) && (vcount_q < V_ACTIVE_C);
    hs_on_s   = (hcount_q >= HS_START_C) && (hcount_q < HS_END_C);
    vs_on_s   = (vcount_q >= VS_START_C) && (vcount_q < VS_END_C);
    h_last_s  = (hcount_q == H_LAST_C);
    v_last_s  = (vcount_q == V_LAST_C);
    // Commit happens on the pixel tick that leaves the last visible pixel.
    commit_s  = pix_en_q && (hcount_q == H_COMMIT_C) && (vcount_q == V_COMMIT_C);
  end

  // Pixel enable, raster counters and round-robin register index.
  always_comb begin
    pix_en_d   = ~pix_en_q;
    reg_addr_d = reg_addr_q + 3'd1;
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    if (pix_en_q) begin
      if (h_last_s) begin
        hcount_d = 10'd0;
        if (v_last_s) begin
          vcount_d = 10'd0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
      end
    end else begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
    end
  end

  // Pending bank takes bus writes; active bank copies the pre-write pending bank at commit.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en_s && (avs.address == 3'(i))) begin
        pending_d[i] = avs.writedata;
      end else begin
        pending_d[i] = pending_q[i];
      end
      if (commit_s) begin
        active_d[i] = pending_q[i];
      end else begin
        active_d[i] = active_q[i];
      end
    end
  end

  // Colour, sync and blank are captured together on each pixel tick so they stay aligned.
  always_comb begin
    rgb_d         = rgb_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    frame_start_d = commit_s;
    if (pix_en_q) begin
      hs_d      = ~hs_on_s;
      vs_d      = ~vs_on_s;
      blank_n_d = visible_s;
      if (visible_s) begin
        rgb_d = RGB_input;
      end else begin
        rgb_d = 24'd0;
      end
    end else begin
      rgb_d     = rgb_q;
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
    end
  end

  // State registers; reset parks the raster at (0,0) with idle video levels and empty banks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_en_q      <= 1'b0;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      reg_addr_q    <= 3'd0;
      rgb_q         <= 24'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        pending_q[i] <= 32'd0;
        active_q[i]  <= 32'd0;
      end
    end else begin
      pix_en_q      <= pix_en_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      reg_addr_q    <= reg_addr_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
      end
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign reg_addr    = reg_addr_q;
  assign reg_data    = active_q[reg_addr_q];
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_n = blank_n_q;
  assign VGA_CLK     = pix_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Testbench for vga_scan_driver, using a reduced raster so that several whole
// frames fit in a short run.
// The reference model derives every output from one number: the count of clk
// edges since reset release.
module tb_vga_scan_driver;

  localparam int HA  = 16;
  localparam int HT  = 24;
  localparam int HSS = 18;
  localparam int HSE = 21;
  localparam int VA  = 10;
  localparam int VT  = 14;
  localparam int VSS = 11;
  localparam int VSE = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic [2:0]  reg_addr;
  logic [31:0] reg_data;
  logic [23:0] RGB_input;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK, frame_start;

  vga_scan_driver_if bus();

  vga_scan_driver #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
    .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE)
  ) dut (
    .clk(clk), .reset(reset), .avs(bus),
    .hcount(hcount), .vcount(vcount), .reg_addr(reg_addr), .reg_data(reg_data),
    .RGB_input(RGB_input), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .VGA_CLK(VGA_CLK), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // Scoreboard counters.
  int tests = 0;
  int fails = 0;

  // Reference model state.
  int          k;
  logic [31:0] pend_m [8];
  logic [31:0] act_m  [8];
  logic        e_hs, e_vs, e_bn, e_fs;
  logic [23:0] e_rgb;

  // Stimulus controls.
  bit          wr_rand;
  bit          rgb_rand;
  bit          force_wr;
  logic [2:0]  force_addr;
  logic [31:0] force_data;

  // Window counters covering exactly one frame of output samples.
  bit win_on;
  int hs_lo, vs_lo, bn_hi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic timeout(input string name, input bit reached);
    if (!reached) begin
      tests++;
      fails++;
      $display("FAIL timeout %s: got not-reached expected reached (edge %0d)", name, k);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      pend_m[i] = 32'd0;
      act_m[i]  = 32'd0;
    end
    e_hs  = 1'b1;
    e_vs  = 1'b1;
    e_bn  = 1'b0;
    e_rgb = 24'd0;
    e_fs  = 1'b0;
  endtask

  // One clk edge of the model.
  // pix_en equals k mod 2, so the edge after an odd k is a pixel tick.
  // That tick leaves scan position floor(k/2).
  task automatic model_edge();
    int  pb, h, v;
    bit  commit;
    commit = 1'b0;
    if (reset) begin
      if ((k % 2) == 1) begin
        pb     = k / 2;
        h      = pb % HT;
        v      = (pb / HT) % VT;
        commit = (h == HA - 1) && (v == VA - 1);
        e_hs   = !((h >= HSS) && (h < HSE));
        e_vs   = !((v >= VSS) && (v < VSE));
        e_bn   = (h < HA) && (v < VA);
        e_rgb  = e_bn ? RGB_input : 24'd0;
        if (commit) begin
          for (int i = 0; i < 8; i++) act_m[i] = pend_m[i];
        end
      end
      e_fs = commit;
      if (bus.chipselect && bus.write) pend_m[bus.address] = bus.writedata;
      k++;
    end
  endtask

  task automatic compare_all();
    int p;
    p = k / 2;
    check("hcount",      32'(hcount),      32'(p % HT));
    check("vcount",      32'(vcount),      32'((p / HT) % VT));
    check("reg_addr",    32'(reg_addr),    32'(k % 8));
    check("VGA_CLK",     32'(VGA_CLK),     32'(k % 2));
    check("reg_data",    reg_data,         act_m[k % 8]);
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("VGA_R",       32'(VGA_R),       32'(e_rgb[23:16]));
    check("VGA_G",       32'(VGA_G),       32'(e_rgb[15:8]));
    check("VGA_B",       32'(VGA_B),       32'(e_rgb[7:0]));
    check("VGA_HS",      32'(VGA_HS),      32'(e_hs));
    check("VGA_VS",      32'(VGA_VS),      32'(e_vs));
    check("VGA_BLANK_n", 32'(VGA_BLANK_n), 32'(e_bn));
    if (win_on && (k >= 2) && (k < 2 + 2 * HT * VT)) begin
      if (!VGA_HS) hs_lo++;
      if (!VGA_VS) vs_lo++;
      if (VGA_BLANK_n) bn_hi++;
    end
  endtask

  task automatic drive_inputs();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    if (force_wr) begin
      bus.chipselect = 1'b1;
      bus.write      = 1'b1;
      bus.address    = force_addr;
      bus.writedata  = force_data;
      force_wr       = 1'b0;
    end else if (wr_rand) begin
      bus.chipselect = ($urandom_range(2) == 0);
      bus.write      = ($urandom_range(2) == 0);
      bus.address    = 3'($urandom_range(7));
      bus.writedata  = $urandom;
    end
    if (rgb_rand) RGB_input = 24'($urandom);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    compare_all();
    drive_inputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    force_wr   = 1'b1;
    force_addr = a;
    force_data = d;
    step();
  endtask

  initial begin
    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
    RGB_input      = 24'd0;
    wr_rand = 1'b0; rgb_rand = 1'b0; force_wr = 1'b0;
    force_addr = 3'd0; force_data = 32'd0;
    win_on = 1'b0; hs_lo = 0; vs_lo = 0; bn_hi = 0;
    model_reset();

    // Reset values.
    @(negedge clk);
    check("rst_hcount", 32'(hcount), 32'd0);
    check("rst_VGA_HS", 32'(VGA_HS), 32'd1);
    check("rst_BLANK_n", 32'(VGA_BLANK_n), 32'd0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;

    // Constant colour over one full frame; pin the commit timing and the frame window.
    RGB_input = 24'hFF8000;
    win_on    = 1'b1;
    for (int i = 0; i < 3000 && k != 463; i++) step();
    timeout("reach_463", k == 463);
    check("fs_before_commit", 32'(frame_start), 32'd0);
    step();
    check("fs_at_commit", 32'(frame_start), 32'd1);
    check("hcount_after_commit", 32'(hcount), 32'd16);
    check("vcount_after_commit", 32'(vcount), 32'd9);
    check("last_pixel_R", 32'(VGA_R), 32'hFF);
    check("last_pixel_G", 32'(VGA_G), 32'h80);
    check("last_pixel_B", 32'(VGA_B), 32'h00);
    step();
    check("fs_one_clk", 32'(frame_start), 32'd0);
    step();
    check("blank_R", 32'(VGA_R), 32'h00);
    check("blank_BLANK_n", 32'(VGA_BLANK_n), 32'd0);
    for (int i = 0; i < 3000 && k != 2 + 2 * HT * VT; i++) step();
    timeout("frame_window", k == 2 + 2 * HT * VT);
    win_on = 1'b0;
    check("hs_low_clk_per_frame", 32'(hs_lo), 32'd84);
    check("vs_low_clk_per_frame", 32'(vs_lo), 32'd48);
    check("blank_n_high_clk_per_frame", 32'(bn_hi), 32'd320);

    // Mid-frame writes become visible only after the next commit; the last write wins.
    rgb_rand = 1'b1;
    bus_write(3'd3, 32'h0000_1234);
    bus_write(3'd0, 32'h0000_000A);
    bus_write(3'd0, 32'h0000_000B);
    for (int i = 0; i < 16 && (k % 8) != 3; i++) step();
    check("active3_before_commit", reg_data, 32'd0);
    for (int i = 0; i < 2000 && !(k > 1136 && (k % 8) == 3); i++) step();
    timeout("commit2_addr3", k > 1136 && (k % 8) == 3);
    check("active3_after_commit", reg_data, 32'h0000_1234);
    for (int i = 0; i < 16 && (k % 8) != 0; i++) step();
    check("active0_last_write", reg_data, 32'h0000_000B);

    // A write in the very clk of the commit waits one whole frame.
    for (int i = 0; i < 2000 && k != 1807; i++) step();
    timeout("reach_1807", k == 1807);
    bus_write(3'd5, 32'h00C0_FFEE);
    check("fs_commit3", 32'(frame_start), 32'd1);
    for (int i = 0; i < 16 && (k % 8) != 5; i++) step();
    check("commit_clk_write_absent", reg_data, 32'd0);
    for (int i = 0; i < 2000 && !(k > 2480 && (k % 8) == 5); i++) step();
    timeout("commit4_addr5", k > 2480 && (k % 8) == 5);
    check("commit_clk_write_present", reg_data, 32'h00C0_FFEE);

    // Random colour and random bus traffic over about two frames.
    wr_rand = 1'b1;
    for (int i = 0; i < 1400; i++) step();

    // Asynchronous reset in mid-frame, held for three clocks.
    for (int i = 0; i < 2000 && !(((k / 2) % HT) == 7 && ((k / 2 / HT) % VT) == 5 && (k % 2) == 1); i++) step();
    timeout("reach_mid_frame", ((k / 2) % HT) == 7 && ((k / 2 / HT) % VT) == 5);
    reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_hcount", 32'(hcount), 32'd0);
    check("async_rst_vcount", 32'(vcount), 32'd0);
    check("async_rst_VGA_HS", 32'(VGA_HS), 32'd1);
    check("async_rst_VGA_R", 32'(VGA_R), 32'd0);
    check("async_rst_reg_data", reg_data, 32'd0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    check("restart_hcount_first", 32'(hcount), 32'd0);
    check("restart_VGA_CLK", 32'(VGA_CLK), 32'd1);
    step();
    check("restart_hcount_second", 32'(hcount), 32'd1);
    for (int i = 0; i < 1500; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
